// File: rtl/map_port_arbiter.sv
// ==== map_port_arbiter : map BRAM read port shared by renderer and two collision-query clients ====
// ==== rev 1.0 =====================================================================================
`default_nettype none

module map_port_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 4,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              render_active,
  input  logic [ADDR_W-1:0] render_addr,
  output logic [DATA_W-1:0] render_data,
  input  logic [1:0]        q_req,
  input  logic [ADDR_W-1:0] q_addr0,
  input  logic [ADDR_W-1:0] q_addr1,
  output logic [1:0]        q_gnt,
  output logic [1:0]        q_rvalid,
  output logic [DATA_W-1:0] q_rdata,
  output logic [1:0]        q_starve,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STARVE_MAX - 1);

  typedef enum logic {
    RENDER = 1'b0,
    FREE   = 1'b1
  } mode_t;

  mode_t             mode;
  logic              rr_ptr;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] rdata_hold;
  logic              pipe_v  [READ_LAT];
  logic              pipe_id [READ_LAT];
  logic [CNT_W-1:0]  wait_cnt [2];
  logic [1:0]        starve;
  logic              out_v;

  // Mode follows render_active in the same cycle so the renderer is never delayed.
  always_comb begin
    mode = render_active ? RENDER : FREE;
    gnt  = 2'b00;
    if (!rst && mode == FREE) begin
      case (q_req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    mem_addr = addr_hold;
    if (render_active)
      mem_addr = render_addr;
    else if (gnt[0])
      mem_addr = q_addr0;
    else if (gnt[1])
      mem_addr = q_addr1;
  end

  // An in-flight read is dropped while rst is high, even at its output stage.
  assign out_v       = pipe_v[READ_LAT-1] && !rst;
  assign q_gnt       = gnt;
  assign q_rvalid    = out_v ? (pipe_id[READ_LAT-1] ? 2'b10 : 2'b01) : 2'b00;
  assign q_rdata     = out_v ? mem_dout : rdata_hold;
  assign q_starve    = starve;
  assign render_data = mem_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= 1'b0;
      addr_hold  <= '0;
      rdata_hold <= '0;
      starve     <= 2'b00;
      for (int s = 0; s < READ_LAT; s++) begin
        pipe_v[s]  <= 1'b0;
        pipe_id[s] <= 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      if (|gnt)
        rr_ptr <= gnt[0];
      addr_hold  <= mem_addr;
      rdata_hold <= q_rdata;
      pipe_v[0]  <= |gnt;
      pipe_id[0] <= gnt[1];
      for (int s = 1; s < READ_LAT; s++) begin
        pipe_v[s]  <= pipe_v[s-1];
        pipe_id[s] <= pipe_id[s-1];
      end
      // Saturating wait counters; the starve flag is sticky until reset.
      for (int i = 0; i < 2; i++) begin
        if (!q_req[i] || gnt[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != CNT_MAX) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
          if (wait_cnt[i] == CNT_PRE)
            starve[i] <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_map_port_arbiter.sv
// ==== tb_map_port_arbiter : vector table, corner sequences and randomized run against a queue model ====
// ==== rev 1.0 ===========================================================================================
`default_nettype none

module tb_map_port_arbiter;

  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 4;
  localparam int READ_LAT   = 2;
  localparam int STARVE_MAX = 8;

  localparam logic [16:0] RA = 17'h0F0F0;
  localparam logic [16:0] A0 = 17'h00123;
  localparam logic [16:0] A1 = 17'h1ABCD;

  logic              clk = 1'b0;
  logic              rst;
  logic              render_active;
  logic [ADDR_W-1:0] render_addr;
  logic [DATA_W-1:0] render_data;
  logic [1:0]        q_req;
  logic [ADDR_W-1:0] q_addr0;
  logic [ADDR_W-1:0] q_addr1;
  logic [1:0]        q_gnt;
  logic [1:0]        q_rvalid;
  logic [DATA_W-1:0] q_rdata;
  logic [1:0]        q_starve;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;

  map_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst), .render_active(render_active), .render_addr(render_addr),
    .render_data(render_data), .q_req(q_req), .q_addr0(q_addr0), .q_addr1(q_addr1),
    .q_gnt(q_gnt), .q_rvalid(q_rvalid), .q_rdata(q_rdata), .q_starve(q_starve),
    .mem_addr(mem_addr), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // BRAM stand-in: contents are a fixed function of the address, READ_LAT cycles late.
  function automatic logic [3:0] bram_f(input logic [16:0] a);
    return a[3:0] + a[7:4];
  endfunction

  logic [16:0] ba [READ_LAT];
  always @(posedge clk) begin
    ba[0] <= mem_addr;
    for (int k = 1; k < READ_LAT; k++) ba[k] <= ba[k-1];
  end
  assign mem_dout = bram_f(ba[READ_LAT-1]);

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: round-robin preference, list of outstanding reads with due cycles.
  typedef struct { int due; logic id; logic [3:0] data; } fl_t;
  fl_t         m_q[$];
  int          m_pref = 0;
  logic [16:0] m_last_addr = '0;
  logic [3:0]  m_rdata = '0;
  int          m_cnt [2] = '{0, 0};
  logic [1:0]  m_starve = 2'b00;
  logic [1:0]  m_gnt = 2'b00;

  task automatic sample();
    logic [16:0] e_addr;
    logic [1:0]  e_rv;
    logic [3:0]  e_rd;
    @(negedge clk);
    m_gnt = 2'b00;
    if (!rst && !render_active && q_req != 2'b00)
      m_gnt = (q_req == 2'b11) ? ((m_pref == 0) ? 2'b01 : 2'b10) : q_req;
    e_addr = render_active ? render_addr : m_gnt[0] ? q_addr0 : m_gnt[1] ? q_addr1 : m_last_addr;
    e_rv = 2'b00;
    e_rd = m_rdata;
    if (!rst && m_q.size() > 0 && m_q[0].due == cyc) begin
      e_rv = m_q[0].id ? 2'b10 : 2'b01;
      e_rd = m_q[0].data;
    end
    chk("model_gnt", q_gnt, m_gnt);
    chk("model_mem_addr", mem_addr, e_addr);
    chk("model_rvalid", q_rvalid, e_rv);
    chk("model_rdata", q_rdata, e_rd);
    chk("model_starve", q_starve, m_starve);
    if (rst) begin
      m_q.delete();
      m_pref = 0; m_last_addr = '0; m_rdata = '0; m_starve = 2'b00;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      if (e_rv != 2'b00) void'(m_q.pop_front());
      m_rdata = e_rd;
      m_last_addr = e_addr;
      if (m_gnt != 2'b00) begin
        m_q.push_back('{cyc + READ_LAT, m_gnt[1], bram_f(e_addr)});
        m_pref = m_gnt[0] ? 1 : 0;
      end
      for (int i = 0; i < 2; i++) begin
        if (q_req[i] && !m_gnt[i]) m_cnt[i] = (m_cnt[i] < STARVE_MAX) ? m_cnt[i] + 1 : STARVE_MAX;
        else m_cnt[i] = 0;
        if (m_cnt[i] >= STARVE_MAX) m_starve[i] = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic ra, input logic [1:0] req);
    render_active = ra;
    q_req = req;
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b1, 2'b00);
    rst = 1'b0;
  endtask

  typedef struct {
    logic ra; logic [1:0] req; logic [1:0] gnt; logic [16:0] addr; logic [1:0] rv; logic [3:0] rd;
  } vec_t;
  vec_t tbl [12];

  initial begin
    logic [1:0] pend;
    rst = 1'b1; render_active = 1'b1; render_addr = RA; q_req = 2'b00;
    q_addr0 = A0; q_addr1 = A1;

    // bram_f(A0)=5, bram_f(A1)=9; rvalid trails grants by two rows
    tbl[0]  = '{1'b1, 2'b11, 2'b00, RA, 2'b00, 4'h0};
    tbl[1]  = '{1'b0, 2'b11, 2'b01, A0, 2'b00, 4'h0};
    tbl[2]  = '{1'b0, 2'b11, 2'b10, A1, 2'b00, 4'h0};
    tbl[3]  = '{1'b0, 2'b11, 2'b01, A0, 2'b01, 4'h5};
    tbl[4]  = '{1'b0, 2'b10, 2'b10, A1, 2'b10, 4'h9};
    tbl[5]  = '{1'b0, 2'b11, 2'b01, A0, 2'b01, 4'h5};
    tbl[6]  = '{1'b0, 2'b01, 2'b01, A0, 2'b10, 4'h9};
    tbl[7]  = '{1'b0, 2'b11, 2'b10, A1, 2'b01, 4'h5};
    tbl[8]  = '{1'b0, 2'b00, 2'b00, A1, 2'b01, 4'h5};
    tbl[9]  = '{1'b1, 2'b01, 2'b00, RA, 2'b10, 4'h9};
    tbl[10] = '{1'b0, 2'b00, 2'b00, RA, 2'b00, 4'h9};
    tbl[11] = '{1'b0, 2'b11, 2'b01, A0, 2'b00, 4'h9};

    advance();
    do_reset();
    chk("reset_gnt", q_gnt, 2'b00);
    chk("reset_rvalid", q_rvalid, 2'b00);
    chk("reset_rdata", q_rdata, 4'h0);
    chk("reset_starve", q_starve, 2'b00);

    // Render hogging the port: no grants, address always the renderer's
    for (int k = 0; k < 50; k++) begin
      render_addr = 17'(k * 311);
      render_active = 1'b1; q_req = 2'b11;
      sample();
      chk("render_mem_addr", mem_addr, render_addr);
      chk("render_gnt", q_gnt, 2'b00);
      advance();
    end
    render_addr = RA;
    do_reset();

    for (int r = 0; r < 12; r++) begin
      render_active = tbl[r].ra; q_req = tbl[r].req;
      sample();
      chk("tbl_gnt", q_gnt, tbl[r].gnt);
      chk("tbl_mem_addr", mem_addr, tbl[r].addr);
      chk("tbl_rvalid", q_rvalid, tbl[r].rv);
      chk("tbl_rdata", q_rdata, tbl[r].rd);
      advance();
    end

    // P2 granted, rendering resumes next cycle: the read still completes
    do_reset();
    render_active = 1'b0; q_req = 2'b10;
    sample(); chk("t4_gnt", q_gnt, 2'b10); advance();
    render_active = 1'b1; q_req = 2'b00;
    sample(); chk("t4_rvalid_early", q_rvalid, 2'b00); advance();
    sample(); chk("t4_rvalid", q_rvalid, 2'b10); chk("t4_rdata", q_rdata, 4'h9); advance();

    // Starvation: flag rises once eight waiting cycles have elapsed and is sticky
    do_reset();
    for (int k = 0; k < 10; k++) begin
      render_active = 1'b1; q_req = 2'b01;
      sample();
      chk("t5_starve", q_starve, (k >= STARVE_MAX) ? 2'b01 : 2'b00);
      advance();
    end
    render_active = 1'b0; q_req = 2'b01;
    sample(); chk("t5_gnt", q_gnt, 2'b01); chk("t5_starve_at_gnt", q_starve, 2'b01); advance();
    cycle(1'b0, 2'b00);
    sample(); chk("t5_starve_sticky", q_starve, 2'b01); advance();
    do_reset();
    sample(); chk("t5_starve_cleared", q_starve, 2'b00); advance();

    // Reset one cycle after a grant drops the read
    do_reset();
    cycle(1'b0, 2'b01);
    cycle(1'b0, 2'b00);
    sample(); chk("t6_first_rdata", q_rdata, 4'h5); advance();
    render_active = 1'b0; q_req = 2'b01;
    sample(); chk("t6_gnt", q_gnt, 2'b01); advance();
    rst = 1'b1; q_req = 2'b00;
    sample(); chk("t6_rst_gnt", q_gnt, 2'b00); chk("t6_rst_rvalid", q_rvalid, 2'b00); advance();
    rst = 1'b0;
    sample();
    chk("t6_post_rvalid", q_rvalid, 2'b00);
    chk("t6_post_rdata", q_rdata, 4'h0);
    chk("t6_post_mem_addr", mem_addr, 17'h0);
    chk("t6_post_starve", q_starve, 2'b00);
    advance();
    sample(); chk("t6_late_rvalid", q_rvalid, 2'b00); advance();

    // Randomized traffic under the handshake rules
    for (int k = 0; k < 3000; k++) begin
      pend = q_req & ~m_gnt;
      rst = ($urandom_range(0, 199) == 0);
      render_active = ($urandom_range(0, 9) < 6);
      render_addr = 17'($urandom);
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) begin
          q_req[i] = ($urandom_range(0, 15) != 0);
        end else begin
          q_req[i] = $urandom_range(0, 1) == 1;
          if (i == 0) q_addr0 = 17'($urandom);
          else        q_addr1 = 17'($urandom);
        end
      end
      sample();
      advance();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
